// File: rtl/traffic_pkg.sv
// Shared encodings for the N-way traffic controller: FSM states, lamp codes
// and small elaboration-time helpers.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2,
    ST_FLASH  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    LT_GREEN  = 2'b00,
    LT_YELLOW = 2'b01,
    LT_RED    = 2'b10,
    LT_OFF    = 2'b11
  } light_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // A single-direction build would give $clog2 == 0; keep the index at least 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first requesting direction after i_cur, wrapping at N_DIR-1.
// i_cur itself is never picked; o_any_other flags that some other direction asks.
module rr_pick
  import traffic_pkg::*;
#(
  parameter int N_DIR = 4,
  parameter int IDX_W = idx_width(N_DIR)
) (
  input  logic [N_DIR-1:0] i_req,
  input  logic [IDX_W-1:0] i_cur,
  output logic [IDX_W-1:0] o_next,
  output logic             o_any_other
);

  logic [IDX_W-1:0] w_idx;

  // Scan farthest-first so the last hit written is the nearest one after i_cur.
  always_comb begin
    // NOTE: every output gets a default before the loop, otherwise a path
    // with no request would leave it unassigned and infer a latch.
    o_next      = i_cur;
    o_any_other = 1'b0;
    w_idx       = i_cur;
    for (int i = N_DIR - 1; i >= 1; i--) begin
      w_idx = IDX_W'((int'(i_cur) + i) % N_DIR);
      if (i_req[w_idx]) begin
        o_next      = w_idx;
        o_any_other = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_ctrl_n.sv
// N-direction traffic light controller: round-robin green with min/max dwell,
// fixed yellow and all-red, and a flashing-red maintenance mode.
module traffic_ctrl_n
  import traffic_pkg::*;
#(
  parameter int N_DIR      = 4,
  parameter int GREEN_MIN  = 4,
  parameter int GREEN_MAX  = 16,
  parameter int YELLOW_CYC = 2,
  parameter int ALLRED_CYC = 1,
  parameter int FLASH_HALF = 3,
  localparam int IDX_W     = idx_width(N_DIR)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_DIR-1:0]     traffic_i,
  input  logic                 flash_i,
  output logic [2*N_DIR-1:0]   light_o,
  output logic [IDX_W-1:0]     dir_o,
  output logic                 flash_o
);

  localparam int K_MAX = max2(max2(GREEN_MAX, YELLOW_CYC), max2(ALLRED_CYC, FLASH_HALF));
  localparam int K_W   = $clog2(K_MAX + 1);

  localparam logic [K_W-1:0] K_ONE  = K_W'(1);
  localparam logic [K_W-1:0] K_SAT  = K_W'(K_MAX);
  localparam logic [K_W-1:0] K_GMIN = K_W'(GREEN_MIN);
  localparam logic [K_W-1:0] K_GMAX = K_W'(GREEN_MAX);
  localparam logic [K_W-1:0] K_YEL  = K_W'(YELLOW_CYC);
  localparam logic [K_W-1:0] K_AR   = K_W'(ALLRED_CYC);
  localparam logic [K_W-1:0] K_FH   = K_W'(FLASH_HALF);

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_d, w_d_nxt;
  logic [IDX_W-1:0] r_nd, w_nd_nxt;
  logic [K_W-1:0]   r_k, w_k_nxt;
  logic             r_flash_off, w_flash_off_nxt;
  logic [IDX_W-1:0] w_pick;
  logic             w_any_other;

  rr_pick #(
    .N_DIR (N_DIR),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_req       (traffic_i),
    .i_cur       (r_d),
    .o_next      (w_pick),
    .o_any_other (w_any_other)
  );

  // In FLASH, r_k counts within the current red/off half-period.
  always_comb begin
    w_state_nxt     = r_state;
    w_d_nxt         = r_d;
    w_nd_nxt        = r_nd;
    w_flash_off_nxt = r_flash_off;
    w_k_nxt         = (r_k == K_SAT) ? r_k : r_k + K_ONE;

    case (r_state)
      ST_GREEN: begin
        if (flash_i) begin
          w_state_nxt = ST_YELLOW;
        end else if (r_k >= K_GMIN && w_any_other &&
                     (!traffic_i[r_d] || r_k >= K_GMAX)) begin
          w_state_nxt = ST_YELLOW;
          w_nd_nxt    = w_pick;
        end
      end
      ST_YELLOW: begin
        if (r_k >= K_YEL) w_state_nxt = flash_i ? ST_FLASH : ST_ALLRED;
      end
      ST_ALLRED: begin
        if (r_k >= K_AR) begin
          if (flash_i) begin
            w_state_nxt = ST_FLASH;
          end else begin
            w_state_nxt = ST_GREEN;
            w_d_nxt     = r_nd;
          end
        end
      end
      ST_FLASH: begin
        if (!flash_i) begin
          w_state_nxt = ST_ALLRED;
          w_nd_nxt    = '0;
        end else if (r_k >= K_FH) begin
          w_flash_off_nxt = !r_flash_off;
          w_k_nxt         = K_ONE;
        end
      end
      default: w_state_nxt = ST_GREEN;
    endcase

    if (w_state_nxt != r_state) w_k_nxt = K_ONE;
    if (w_state_nxt == ST_FLASH && r_state != ST_FLASH) w_flash_off_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    if (rst) begin
      r_state     <= ST_GREEN;
      r_d         <= '0;
      r_nd        <= '0;
      r_k         <= K_ONE;
      r_flash_off <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_d         <= w_d_nxt;
      r_nd        <= w_nd_nxt;
      r_k         <= w_k_nxt;
      r_flash_off <= w_flash_off_nxt;
    end
  end

  always_comb begin
    for (int j = 0; j < N_DIR; j++) begin
      light_o[2*j +: 2] = LT_RED;
      if (r_state == ST_FLASH && r_flash_off) begin
        light_o[2*j +: 2] = LT_OFF;
      end else if (r_state == ST_GREEN && r_d == IDX_W'(j)) begin
        light_o[2*j +: 2] = LT_GREEN;
      end else if (r_state == ST_YELLOW && r_d == IDX_W'(j)) begin
        light_o[2*j +: 2] = LT_YELLOW;
      end
    end
  end

  assign dir_o   = r_d;
  assign flash_o = (r_state == ST_FLASH);

endmodule
